// File: rtl/systolic_drain.sv
// Drains one captured row of MAC accumulators as requantised words over valid/ready.
// Build option: define SYSTOLIC_DRAIN_RELU_EN to clamp negative outputs to zero.
module systolic_drain #(
  parameter int unsigned N         = 4,
  parameter int unsigned ACC_WIDTH = 17,
  parameter int unsigned OUT_WIDTH = 8,
  parameter int unsigned SHIFT     = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N*ACC_WIDTH-1:0] acc_i,
  input  logic                   capture_i,
  output logic [OUT_WIDTH-1:0]   out_data_o,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] out_idx_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic                   out_last_o,
  output logic                   busy_o,
  output logic                   overrun_o,
  output logic                   acc_clr_o
);

  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MAX =
    ACC_WIDTH'((1 << (OUT_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH-1:0] OUT_MIN = -OUT_MAX - ACC_WIDTH'(1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_e;

  state_e                        state_q, state_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic signed [ACC_WIDTH-1:0]   snap_q [N];
  logic signed [ACC_WIDTH-1:0]   snap_d [N];
  logic                          overrun_q, overrun_d;
  logic                          acc_clr_q, acc_clr_d;

  logic                          xfer;
  logic                          at_last;
  logic                          take;

  // Shift (floor), saturate, then optional ReLU.
  function automatic logic [OUT_WIDTH-1:0] requant(input logic signed [ACC_WIDTH-1:0] v);
    logic signed [ACC_WIDTH-1:0] s;
    logic [OUT_WIDTH-1:0]        r;
    s = v >>> SHIFT;
    if (s > OUT_MAX) begin
      r = OUT_MAX[OUT_WIDTH-1:0];
    end else if (s < OUT_MIN) begin
      r = OUT_MIN[OUT_WIDTH-1:0];
    end else begin
      r = s[OUT_WIDTH-1:0];
    end
`ifdef SYSTOLIC_DRAIN_RELU_EN
    if (r[OUT_WIDTH-1]) begin
      r = '0;
    end
`else
`endif
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      overrun_q <= 1'b0;
      acc_clr_q <= 1'b0;
      for (int k = 0; k < int'(N); k++) begin
        snap_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      overrun_q <= overrun_d;
      acc_clr_q <= acc_clr_d;
      for (int k = 0; k < int'(N); k++) begin
        snap_q[k] <= snap_d[k];
      end
    end
  end

  assign xfer    = (state_q == STREAM) && out_ready_i;
  assign at_last = (idx_q == LAST_IDX);
  // A capture is only taken when the snapshot register is free by the next cycle.
  assign take    = capture_i && ((state_q == IDLE) || (xfer && at_last));

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    overrun_d = overrun_q;
    acc_clr_d = 1'b0;
    for (int k = 0; k < int'(N); k++) begin
      snap_d[k] = snap_q[k];
    end

    case (state_q)
      IDLE: begin
        if (take) begin
          state_d = STREAM;
        end
      end
      STREAM: begin
        if (xfer) begin
          if (at_last) begin
            state_d = take ? STREAM : IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
        if (capture_i && !take) begin
          overrun_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase

    if (take) begin
      idx_d     = '0;
      acc_clr_d = 1'b1;
      for (int k = 0; k < int'(N); k++) begin
        snap_d[k] = acc_i[k*ACC_WIDTH +: ACC_WIDTH];
      end
    end
  end

  // Outputs are decoded from registered state only; data is zero while idle.
  assign out_valid_o = (state_q == STREAM);
  assign busy_o      = (state_q == STREAM);
  assign out_idx_o   = out_valid_o ? idx_q : '0;
  assign out_last_o  = out_valid_o && at_last;
  assign out_data_o  = out_valid_o ? requant(snap_q[idx_q]) : '0;
  assign overrun_o   = overrun_q;
  assign acc_clr_o   = acc_clr_q;

endmodule

// File: doc/systolic_drain.md
Name: systolic_drain

Overview:
- Reader side of the MAC array's accumulator outputs.
- Snapshots one row of N accumulators from the row's MAC elements on a capture strobe.
- Requantises each value (arithmetic shift right, then saturate to OUT_WIDTH).
- Streams the values out one per beat over a valid/ready interface to the FFN activation/writeback stage.

Parameters:
- N, 4, number of accumulator lanes captured per snapshot (the systolic array width).
- ACC_WIDTH, 17, signed width of each accumulator lane.
- OUT_WIDTH, 8, signed width of each streamed output word.
- SHIFT, 2, arithmetic right-shift amount applied before saturation; legal range 0..ACC_WIDTH-1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- acc_i  input  N*ACC_WIDTH  packed signed accumulators; lane k occupies bits [k*ACC_WIDTH +: ACC_WIDTH].
- capture_i  input  1  single-cycle strobe: snapshot acc_i.
- out_data_o  output  OUT_WIDTH  signed requantised word.
- out_idx_o  output  $clog2(N) (min 1)  lane index of the current word.
- out_valid_o  output  1  out_data_o, out_idx_o and out_last_o are valid.
- out_ready_i  input  1  downstream accepts the word.
- out_last_o  output  1  current word is lane N-1.
- busy_o  output  1  snapshot held, not fully drained.
- overrun_o  output  1  sticky: a capture was dropped.
- acc_clr_o  output  1  one-cycle pulse telling the array to clear its accumulators.

Behaviour:
- Reset, with rst high at a rising edge:
  - state=IDLE, idx=0, snapshot registers=0.
  - out_valid_o=0, out_last_o=0, busy_o=0, overrun_o=0, acc_clr_o=0.
  - out_data_o=0, out_idx_o=0.
  - Reset mid-stream abandons the snapshot; no further beats are issued.
- State IDLE:
  - capture_i=1 registers all N lanes of acc_i, sets idx=0 and moves to STREAM.
  - acc_clr_o pulses high for exactly the cycle after the capture edge.
- State STREAM:
  - out_valid_o=1, busy_o=1.
  - out_data_o = requant(snapshot[idx]); out_idx_o = idx; out_last_o = (idx==N-1).
  - First valid beat appears the cycle after the capture edge (latency 1).
- Handshake:
  - A beat transfers when out_valid_o and out_ready_i are both high at a rising edge.
  - Without a transfer, out_data_o, out_idx_o and out_last_o hold stable.
  - out_valid_o never drops without a transfer.
  - On transfer with idx<N-1: idx increments.
  - On transfer with idx==N-1: return to IDLE, unless a capture is taken at the same edge.
- Back-to-back capture:
  - capture_i is accepted in IDLE, or in STREAM on the same edge as the last-beat transfer.
  - In the latter case the new snapshot loads, idx resets to 0, state stays STREAM, and acc_clr_o pulses.
  - This sustains full throughput with no bubble.
- Dropped capture:
  - capture_i in STREAM at any other edge is ignored; the snapshot is unaffected and overrun_o sets.
  - overrun_o clears only on rst.
- Requant:
  - Shift: s = snapshot >>> SHIFT, arithmetic, i.e. floor toward negative infinity.
  - Saturation: s > 2^(OUT_WIDTH-1)-1 outputs the max; s < -2^(OUT_WIDTH-1) outputs the min; otherwise the low OUT_WIDTH bits.
  - Requant is purely combinational from the snapshot register and idx; no extra pipeline stage.
- Snapshot capture is on the edge only; later changes on acc_i do not affect queued words.

Optional Feature:
- Macro: SYSTOLIC_DRAIN_RELU_EN.
- Defined: after saturation, any negative result outputs 0 (ReLU fused into the drain). Positive path is unchanged.
- Undefined: signed saturated values pass through unmodified.
- Ports and timing are identical in both builds.

Test Plan:
All scenarios use N=4, ACC_WIDTH=17, OUT_WIDTH=8, SHIFT=2.
- Basic drain with saturation: acc_i lanes {100,-100,1000,-1000}, capture_i pulse, out_ready_i=1 -> 4 consecutive beats starting the cycle after capture.
  - Data 25, -25, 127, -128; idx 0..3; out_last_o only on beat 3.
  - acc_clr_o pulses once; busy_o falls after beat 3.
  - RELU build: data 25, 0, 127, 0.
- Floor rounding: lanes {-3,3,-4,511} -> -1, 0, -1, 127.
- Backpressure: out_ready_i toggled 1,0,0,1 -> each word holds stable while ready=0; no beat lost or duplicated; 4 transfers total.
- Overrun: capture_i during beat 1 with acc_i changed to {7,7,7,7} -> overrun_o=1 and stays 1; remaining beats come from the original snapshot; no acc_clr_o pulse.
- Back-to-back: capture_i on the last-beat transfer edge with acc_i={8,12,16,20} -> the next cycle outputs 2 at idx 0 with no idle cycle; 3, 4, 5 follow; overrun_o stays 0.
- Reset mid-stream: rst high during beat 2 -> the next cycle shows out_valid_o=0, busy_o=0, overrun_o=0; a new capture afterwards streams from idx 0.
